mul_ctrl: RTL and testbench
===========================

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 Parameter REUSE_EN, default 1, SHALL enable (1) or disable (0) the last-product reuse cache.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset; reset is synchronous and active-high.
REQ-004 op_valid  in  1  SHALL indicate a valid multiply request.
REQ-005 op_ready  out  1  SHALL indicate the block accepts a request this cycle.
REQ-006 funct3  in  3  SHALL select the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is treated as MUL.
REQ-007 rs1, rs2  in  32 each  SHALL carry the source operands.
REQ-008 flush  in  1  SHALL invalidate the reuse cache.
REQ-009 res_valid  out  1  SHALL indicate res holds a result.
REQ-010 res_ready  in  1  SHALL indicate the consumer takes res this cycle.
REQ-011 res  out  32  SHALL carry the selected 32-bit result.
REQ-012 m_ai, m_bi  out  33 each  SHALL carry the sign-extended multiplier operands.
REQ-013 m_req  out  1  SHALL request a multiply.
REQ-014 m_zf  out  1  SHALL flag that an operand is zero.
REQ-015 m_r  in  64  SHALL carry the 64-bit product from the multiplier.
REQ-016 m_rdy  in  1  SHALL pulse when m_r is valid.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and RESP; op_ready SHALL equal (state==IDLE).
REQ-018 On accept (op_valid & op_ready), the block SHALL register rs1, rs2, funct3, sa and sb.
REQ-019 Signedness SHALL be: MUL/MULH sa=1, sb=1; MULHSU sa=1, sb=0; MULHU sa=0, sb=0.
REQ-020 m_ai SHALL be {sa&rs1[31], rs1} and m_bi SHALL be {sb&rs2[31], rs2}.
REQ-021 m_zf SHALL be (rs1==0)|(rs2==0), computed on the registered operands.
REQ-022 A cache hit SHALL require REUSE_EN=1, cache valid, equal rs1 and equal rs2, plus: for MUL any stored sa/sb; otherwise stored {sa,sb} equal.
REQ-023 On an accept that hits, the FSM SHALL go IDLE->RESP, load res from the cached 64-bit product, and issue no m_req.
REQ-024 On an accept that misses, the FSM SHALL go IDLE->ISSUE, and m_req SHALL be 1 from the cycle after accept.
REQ-025 In ISSUE, m_req, m_ai, m_bi and m_zf SHALL hold stable until the cycle m_rdy=1.
REQ-026 In the m_rdy=1 cycle, the block SHALL capture m_r, write the cache (product, rs1, rs2, sa, sb, valid=1), load res, and go to RESP.
REQ-027 m_req SHALL be 0 in every state other than ISSUE, so it stays low for at least one cycle between operations.
REQ-028 Result selection SHALL be: MUL -> product[31:0]; MULH/MULHSU/MULHU -> product[63:32].
REQ-029 In RESP, res_valid SHALL be 1 and res SHALL stay stable until res_ready=1.
REQ-030 When res_ready=1 in RESP, the FSM SHALL return to IDLE on the next cycle.
REQ-031 res_ready SHALL be ignored outside RESP.
REQ-032 m_rdy SHALL be ignored outside ISSUE.
REQ-033 A hit SHALL have latency 1 (res_valid in the cycle after accept).
REQ-034 A miss SHALL have latency equal to the multiplier latency plus 1.
REQ-035 flush=1 SHALL clear cache valid in any state.
REQ-036 flush=1 in the m_rdy capture cycle SHALL win: the result is still delivered and the cache is left invalid.
REQ-037 A hit check on the accept cycle of flush=1 SHALL miss.
REQ-038 With REUSE_EN=0, cache valid SHALL be constant 0.

Reset
REQ-039 While rst=1, state SHALL become IDLE and cache valid SHALL be 0.
REQ-040 While rst=1, m_req, m_zf, res_valid, res, m_ai and m_bi SHALL all be 0.
REQ-041 op_ready SHALL be 1 in the first cycle after rst falls.
REQ-042 rst in ISSUE or RESP SHALL abandon the operation: m_req=0 on the next cycle and no result delivered.

Verification
REQ-043 MUL rs1=7, rs2=6 -> m_req=1 the cycle after accept; res=0x0000002A; res_valid until res_ready.
REQ-044 MULH 0xFFFFFFFF x 0xFFFFFFFF -> m_ai=0x1_FFFFFFFF, res=0x00000000. The same operands as MULHU -> m_ai=0x0_FFFFFFFF, res=0xFFFFFFFE, with no cache hit (sign mismatch).
REQ-045 MULHSU rs1=0xFFFFFFFF, rs2=0x00000002 -> m_bi=0x0_00000002, res=0xFFFFFFFF.
REQ-046 MUL rs1=0x1234, rs2=0 -> m_zf=1; m_req drops the cycle after m_rdy; res=0.
REQ-047 MULH 0x12345678 x 0x9ABCDEF0 then MUL with the same operands -> second op has no m_req, res_valid one cycle after accept, res=low word of the first product. Repeat with flush between the two -> m_req issued.
REQ-048 Hold res_ready=0 for 5 cycles in RESP -> res stable, op_ready=0. Assert rst for 1 cycle during ISSUE -> m_req=0 next cycle and an immediate re-issue of the same operands misses the cache.

Source files
------------

// File: rtl/mul_ctrl.sv
// Multiply controller: runs one 32x32 RISC-V multiply at a time through an external
// multiplier and keeps an optional single-entry cache of the last 64-bit product.
module mul_ctrl #(
    parameter bit REUSE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res,
    output logic [32:0] m_ai,
    output logic [32:0] m_bi,
    output logic        m_req,
    output logic        m_zf,
    input  logic [63:0] m_r,
    input  logic        m_rdy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [2:0]  f_reg;
    logic        sa_reg;
    logic        sb_reg;
    logic        m_req_reg;
    logic        m_zf_reg;
    logic        res_valid_reg;
    logic [31:0] res_reg;

    logic [63:0] c_prod_reg;
    logic [31:0] c_a_reg;
    logic [31:0] c_b_reg;
    logic        c_sa_reg;
    logic        c_sb_reg;
    logic        c_valid_reg;

    logic [1:0]  op_sel;
    logic        in_mul;
    logic        in_sa;
    logic        in_sb;
    logic        is_mul;
    logic        hit;
    logic        capture;

    // Encodings 1xx collapse onto MUL before any decoding.
    assign op_sel  = funct3[2] ? 2'b00 : funct3[1:0];
    assign in_mul  = (op_sel == 2'b00);
    assign in_sa   = (op_sel != 2'b11);
    assign in_sb   = ~op_sel[1];
    assign is_mul  = f_reg[2] | (f_reg[1:0] == 2'b00);
    assign capture = (state_reg == ISSUE) & m_rdy;

    // The low word is identical for every signedness, so MUL may reuse any entry.
    assign hit = c_valid_reg & ~flush
               & (rs1 == c_a_reg) & (rs2 == c_b_reg)
               & (in_mul | ({c_sa_reg, c_sb_reg} == {in_sa, in_sb}));

    function automatic logic [31:0] pick(input logic [63:0] p, input logic lo);
        return lo ? p[31:0] : p[63:32];
    endfunction

    assign op_ready  = (state_reg == IDLE);
    assign res_valid = res_valid_reg;
    assign res       = res_reg;
    assign m_req     = m_req_reg;
    assign m_zf      = m_zf_reg;
    assign m_ai      = {sa_reg & a_reg[31], a_reg};
    assign m_bi      = {sb_reg & b_reg[31], b_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            f_reg         <= '0;
            sa_reg        <= 1'b0;
            sb_reg        <= 1'b0;
            m_req_reg     <= 1'b0;
            m_zf_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            res_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        a_reg    <= rs1;
                        b_reg    <= rs2;
                        f_reg    <= funct3;
                        sa_reg   <= in_sa;
                        sb_reg   <= in_sb;
                        m_zf_reg <= (rs1 == 32'd0) | (rs2 == 32'd0);
                        if (hit) begin
                            res_reg       <= pick(c_prod_reg, in_mul);
                            res_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            m_req_reg <= 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (m_rdy) begin
                        m_req_reg     <= 1'b0;
                        res_reg       <= pick(m_r, is_mul);
                        res_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Cache payload needs no reset: it is only ever observed through c_valid_reg.
    always_ff @(posedge clk) begin
        if (capture) begin
            c_prod_reg <= m_r;
            c_a_reg    <= a_reg;
            c_b_reg    <= b_reg;
            c_sa_reg   <= sa_reg;
            c_sb_reg   <= sb_reg;
        end
    end

    generate
        if (REUSE_EN) begin : g_cache
            // Flush outranks a simultaneous capture so the entry stays invalid.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    c_valid_reg <= 1'b0;
                end else if (capture) begin
                    c_valid_reg <= 1'b1;
                end
            end
        end else begin : g_no_cache
            assign c_valid_reg = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a fixed-latency behavioural multiplier.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res;
    logic [32:0] m_ai;
    logic [32:0] m_bi;
    logic        m_req;
    logic        m_zf;
    logic [63:0] m_r = '0;
    logic        m_rdy = 1'b0;

    int checks = 0;
    int failures = 0;

    mul_ctrl #(.REUSE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res(res),
        .m_ai(m_ai), .m_bi(m_bi), .m_req(m_req), .m_zf(m_zf),
        .m_r(m_r), .m_rdy(m_rdy)
    );

    always #5 clk = ~clk;

    // Multiplier model: m_rdy pulses three cycles into a request.
    logic signed [65:0] model_p;
    int mcnt = 0;
    assign model_p = $signed({{33{m_ai[32]}}, m_ai}) * $signed({{33{m_bi[32]}}, m_bi});
    always @(posedge clk) begin
        if (rst || !m_req) begin
            mcnt  <= 0;
            m_rdy <= 1'b0;
        end else if (m_rdy) begin
            m_rdy <= 1'b0;
            mcnt  <= 0;
        end else if (mcnt == 2) begin
            m_rdy <= 1'b1;
            m_r   <= model_p[63:0];
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    // Observations from the most recent transaction
    logic        r_req, r_zf, r_stable, r_req_resp, r_hold_ok, r_idle, r_after_valid, r_timeout;
    logic [32:0] r_ai, r_bi;
    logic [31:0] r_res;
    int          r_lat;

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit acc_flush, input bit rdy_flush, input int hold);
        op_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b; flush = acc_flush;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0; funct3 = '0;
        r_req = m_req; r_ai = m_ai; r_bi = m_bi; r_zf = m_zf;
        r_stable = 1'b1; r_lat = 1; r_timeout = 1'b0;
        while (res_valid !== 1'b1) begin
            if (r_lat >= 40) begin
                r_timeout = 1'b1;
                break;
            end
            if (m_ai !== r_ai || m_bi !== r_bi || m_zf !== r_zf || m_req !== r_req) r_stable = 1'b0;
            if (rdy_flush && m_rdy === 1'b1) flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            r_lat++;
        end
        r_req_resp = m_req;
        r_res = res;
        r_hold_ok = 1'b1;
        checks++;
        if (r_timeout) begin
            failures++;
            $display("FAIL timeout f=%0d a=%h b=%h got res_valid=%b required=1 within 40 cycles", f, a, b, res_valid);
        end else begin
            for (int i = 0; i < hold; i++) begin
                if (res !== r_res || res_valid !== 1'b1 || op_ready !== 1'b0) r_hold_ok = 1'b0;
                @(negedge clk);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        r_idle = op_ready;
        r_after_valid = res_valid;
        $display("op f=%0d a=%h b=%h res=%h lat=%0d req=%0b", f, a, b, r_res, r_lat, r_req);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_req, m_zf, res_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_ctl got=%b required=000", {m_req, m_zf, res_valid});
        end
        checks++;
        if (res !== 32'h0) begin failures++; $display("FAIL reset_res got=%h required=0", res); end
        checks++;
        if (m_ai !== 33'h0 || m_bi !== 33'h0) begin
            failures++; $display("FAIL reset_ops got=%h/%h required=0/0", m_ai, m_bi);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", op_ready); end
        $display("reset done");
    endtask

    task automatic test_mul_basic;
        run_op(3'b000, 32'd7, 32'd6, 0, 0, 0);
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL mul_req got=%b required=1", r_req); end
        checks++;
        if (r_ai !== 33'h0_00000007 || r_zf !== 1'b0) begin
            failures++; $display("FAIL mul_ai_zf got=%h,%b required=7,0", r_ai, r_zf);
        end
        checks++;
        if (r_res !== 32'h0000002A) begin failures++; $display("FAIL mul_res got=%h required=0000002a", r_res); end
        checks++;
        if (r_stable !== 1'b1 || r_req_resp !== 1'b0) begin
            failures++; $display("FAIL mul_issue got stable=%b req_resp=%b required 1,0", r_stable, r_req_resp);
        end
        checks++;
        if (r_idle !== 1'b1 || r_after_valid !== 1'b0) begin
            failures++; $display("FAIL mul_done got ready=%b valid=%b required 1,0", r_idle, r_after_valid);
        end
    endtask

    task automatic test_signed;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        checks++;
        if (r_ai !== 33'h1_FFFFFFFF) begin failures++; $display("FAIL mulh_ai got=%h required=1ffffffff", r_ai); end
        checks++;
        if (r_res !== 32'h0) begin failures++; $display("FAIL mulh_res got=%h required=0", r_res); end
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        checks++;
        if (r_ai !== 33'h0_FFFFFFFF) begin failures++; $display("FAIL mulhu_ai got=%h required=0ffffffff", r_ai); end
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL mulhu_nohit got req=%b required=1", r_req); end
        checks++;
        if (r_res !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu_res got=%h required=fffffffe", r_res); end
        run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 0, 0, 0);
        checks++;
        if (r_bi !== 33'h0_00000002 || r_ai !== 33'h1_FFFFFFFF) begin
            failures++; $display("FAIL mulhsu_ops got=%h/%h required=1ffffffff/000000002", r_ai, r_bi);
        end
        checks++;
        if (r_res !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu_res got=%h required=ffffffff", r_res); end
        // 1xx decodes as MUL and may reuse the MULHSU entry
        run_op(3'b101, 32'hFFFFFFFF, 32'h00000002, 0, 0, 0);
        checks++;
        if (r_req !== 1'b0 || r_lat !== 1) begin
            failures++; $display("FAIL mul1xx_hit got req=%b lat=%0d required 0,1", r_req, r_lat);
        end
        checks++;
        if (r_res !== 32'hFFFFFFFE) begin failures++; $display("FAIL mul1xx_res got=%h required=fffffffe", r_res); end
    endtask

    task automatic test_zero;
        run_op(3'b000, 32'h00001234, 32'h0, 0, 0, 0);
        checks++;
        if (r_zf !== 1'b1) begin failures++; $display("FAIL zero_zf got=%b required=1", r_zf); end
        checks++;
        if (r_res !== 32'h0) begin failures++; $display("FAIL zero_res got=%h required=0", r_res); end
        checks++;
        if (r_stable !== 1'b1 || r_req_resp !== 1'b0) begin
            failures++; $display("FAIL zero_req got stable=%b req_resp=%b required 1,0", r_stable, r_req_resp);
        end
    endtask

    task automatic test_reuse;
        run_op(3'b001, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL reuse_first_req got=%b required=1", r_req); end
        run_op(3'b000, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
        checks++;
        if (r_req !== 1'b0 || r_lat !== 1) begin
            failures++; $display("FAIL reuse_hit got req=%b lat=%0d required 0,1", r_req, r_lat);
        end
        checks++;
        if (r_res !== 32'h242D2080) begin failures++; $display("FAIL reuse_hit_res got=%h required=242d2080", r_res); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_op(3'b000, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL flush_idle_req got=%b required=1", r_req); end
        checks++;
        if (r_res !== 32'h242D2080) begin failures++; $display("FAIL flush_idle_res got=%h required=242d2080", r_res); end
        run_op(3'b000, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0);
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL flush_accept_req got=%b required=1", r_req); end
        run_op(3'b000, 32'd3, 32'd4, 0, 1, 0);
        checks++;
        if (r_res !== 32'd12) begin failures++; $display("FAIL flush_rdy_res got=%h required=c", r_res); end
        run_op(3'b000, 32'd3, 32'd4, 0, 0, 0);
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL flush_rdy_miss got req=%b required=1", r_req); end
    endtask

    task automatic test_backpressure;
        run_op(3'b011, 32'h00010000, 32'h00030000, 0, 0, 5);
        checks++;
        if (r_hold_ok !== 1'b1) begin failures++; $display("FAIL hold_stable got=%b required=1", r_hold_ok); end
        checks++;
        if (r_res !== 32'h3) begin failures++; $display("FAIL hold_res got=%h required=3", r_res); end
    endtask

    task automatic test_reset_issue;
        logic seen;
        run_op(3'b000, 32'd9, 32'd9, 0, 0, 0);
        op_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5;
        @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if (m_req !== 1'b1) begin failures++; $display("FAIL abort_pre_req got=%b required=1", m_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_req !== 1'b0 || op_ready !== 1'b1) begin
            failures++; $display("FAIL abort_req got req=%b ready=%b required 0,1", m_req, op_ready);
        end
        seen = 1'b0;
        repeat (6) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_result got valid=%b required=0", seen); end
        $display("op aborted by reset a=5 b=5");
        run_op(3'b000, 32'd9, 32'd9, 0, 0, 0);
        checks++;
        if (r_req !== 1'b1) begin failures++; $display("FAIL abort_cache_cleared got req=%b required=1", r_req); end
        run_op(3'b000, 32'd5, 32'd5, 0, 0, 0);
        checks++;
        if (r_req !== 1'b1 || r_res !== 32'd25) begin
            failures++; $display("FAIL abort_reissue got req=%b res=%h required 1,19", r_req, r_res);
        end
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_signed;
        test_zero;
        test_reuse;
        test_backpressure;
        test_reset_issue;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
